// File: rtl/xlib_avalon_dma_r.sv
// xlib_avalon_dma_r: single-channel DMA read engine.
// Splits a (start address, word count) command into bursts of at most MAXB
// words, issues them on an Avalon-style read request port, buffers returned
// data in a fall-through FIFO and streams it out with a last-word marker.
// Optional build macro: XLIB_DMA_R_BOUNDARY_EN keeps bursts from crossing a
// 4 KB address boundary.
module xlib_avalon_dma_r #(
  parameter int DW   = 32,
  parameter int AW   = 32,
  parameter int BL   = 4,
  parameter int BI   = 1,
  parameter int MAXB = 8,
  parameter int CW   = 16,
  parameter int FW   = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          c_val,
  output logic          c_rdy,
  input  logic [AW-1:0] c_addr,
  input  logic [CW-1:0] c_len,
  output logic          c_busy,
  output logic          c_done,
  input  logic          m_rrdy,
  output logic          m_rval,
  output logic [BL-1:0] m_rlen,
  output logic [AW-1:0] m_raddr,
  input  logic [DW-1:0] m_rdata,
  input  logic          m_rdval,
  output logic          o_val,
  input  logic          o_rdy,
  output logic [DW-1:0] o_data,
  output logic          o_last
);
  localparam int DEPTH = 1 << FW;
  localparam int BPW   = DW / 8;
  localparam int PW    = FW + 1;
`ifdef XLIB_DMA_R_BOUNDARY_EN
  localparam int BNDB  = 12;
`endif

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DRAIN} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [CW-1:0] rem_q, rem_d;
  logic [CW-1:0] tot_q, tot_d;
  logic [CW-1:0] ocnt_q, ocnt_d;
  logic [CW-1:0] n_q, n_d;
  logic [PW-1:0] pend_q, pend_d;
  logic [PW-1:0] cnt_q, cnt_d;
  logic [FW-1:0] wptr_q, wptr_d;
  logic [FW-1:0] rptr_q, rptr_d;
  logic          m_rval_q, m_rval_d;
  logic [BL-1:0] m_rlen_q, m_rlen_d;
  logic [AW-1:0] m_raddr_q, m_raddr_d;
  logic          c_done_q, c_done_d;
  logic [DW-1:0] mem [DEPTH];
  logic [31:0]   n_w, credit_w;
`ifdef XLIB_DMA_R_BOUNDARY_EN
  logic [31:0]   bnd_w;
`endif
  logic          accept, push, pop;

  assign accept  = m_rval_q & m_rrdy;
  // Data arriving while idle belongs to no command and is dropped.
  assign push    = m_rdval & (state_q != S_IDLE);
  assign pop     = o_val & o_rdy;

  assign c_rdy   = (state_q == S_IDLE);
  assign c_busy  = (state_q != S_IDLE);
  assign c_done  = c_done_q;
  assign m_rval  = m_rval_q;
  assign m_rlen  = m_rlen_q;
  assign m_raddr = m_raddr_q;
  assign o_val   = (cnt_q != '0);
  assign o_data  = o_val ? mem[rptr_q] : '0;
  assign o_last  = o_val && (state_q != S_IDLE) && (ocnt_q == tot_q - CW'(1));

  // Next burst size and free FIFO space not yet promised to in-flight words.
  always_comb begin
    n_w = (32'(rem_q) < 32'(MAXB)) ? 32'(rem_q) : 32'(MAXB);
`ifdef XLIB_DMA_R_BOUNDARY_EN
    bnd_w = ((32'd1 << BNDB) - 32'(addr_q[BNDB-1:0])) / 32'(BPW);
    if (bnd_w < n_w) n_w = bnd_w;
`endif
    credit_w = 32'(DEPTH) - 32'(cnt_q) - 32'(pend_q);
  end

  // Command FSM, request register, FIFO pointers and counters.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rem_d     = rem_q;
    tot_d     = tot_q;
    n_d       = n_q;
    m_rval_d  = m_rval_q;
    m_rlen_d  = m_rlen_q;
    m_raddr_d = m_raddr_q;
    c_done_d  = 1'b0;
    ocnt_d    = pop ? ocnt_q + CW'(1) : ocnt_q;
    pend_d    = pend_q + (accept ? PW'(n_q) : PW'(0)) - PW'(push);
    cnt_d     = cnt_q + PW'(push) - PW'(pop);
    wptr_d    = wptr_q + FW'(push);
    rptr_d    = rptr_q + FW'(pop);
    case (state_q)
      S_IDLE: begin
        if (c_val) begin
          if (c_len != '0) begin
            addr_d  = c_addr;
            rem_d   = c_len;
            tot_d   = c_len;
            ocnt_d  = '0;
            state_d = S_REQ;
          end else begin
            c_done_d = 1'b1;
          end
        end
      end
      S_REQ: begin
        if (accept) begin
          // Request drops for one cycle after every accept.
          m_rval_d = 1'b0;
          addr_d   = addr_q + AW'(32'(n_q) * 32'(BPW));
          rem_d    = rem_q - n_q;
          if (rem_q == n_q) state_d = S_DRAIN;
        end else if (!m_rval_q && (credit_w >= n_w)) begin
          // Only request what the FIFO is guaranteed to absorb.
          m_rval_d  = 1'b1;
          n_d       = CW'(n_w);
          m_rlen_d  = (BI != 0) ? BL'(n_w) : BL'(n_w - 32'd1);
          m_raddr_d = addr_q;
        end
      end
      S_DRAIN: begin
        if (pop && (ocnt_q == tot_q - CW'(1))) begin
          c_done_d = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset aborts any command in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      rem_q     <= '0;
      tot_q     <= '0;
      ocnt_q    <= '0;
      n_q       <= '0;
      pend_q    <= '0;
      cnt_q     <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      m_rval_q  <= 1'b0;
      m_rlen_q  <= '0;
      m_raddr_q <= '0;
      c_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      rem_q     <= rem_d;
      tot_q     <= tot_d;
      ocnt_q    <= ocnt_d;
      n_q       <= n_d;
      pend_q    <= pend_d;
      cnt_q     <= cnt_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      m_rval_q  <= m_rval_d;
      m_rlen_q  <= m_rlen_d;
      m_raddr_q <= m_raddr_d;
      c_done_q  <= c_done_d;
    end
  end

  // FIFO storage; contents are don't-care until the pointers say otherwise.
  always_ff @(posedge clk) begin
    if (push) mem[wptr_q] <= m_rdata;
  end
endmodule

// File: tb/tb_xlib_avalon_dma_r.sv
// Bench for xlib_avalon_dma_r: table of commands plus directed sequences, with
// a bus responder and a reference model that splits commands into bursts.
module tb_xlib_avalon_dma_r;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        c_val = 1'b0, c_rdy, c_busy, c_done;
  logic [31:0] c_addr = '0;
  logic [15:0] c_len = '0;
  logic        m_rrdy = 1'b0, m_rval, m_rdval = 1'b0;
  logic [3:0]  m_rlen;
  logic [31:0] m_raddr, m_rdata = '0;
  logic        o_val, o_rdy = 1'b0, o_last;
  logic [31:0] o_data;
  logic        d0_c_rdy, d0_busy, d0_done, d0_rval, d0_oval, d0_olast;
  logic [3:0]  d0_rlen;
  logic [31:0] d0_raddr, d0_odata;

  xlib_avalon_dma_r u_dut (
    .clk(clk), .rst(rst), .c_val(c_val), .c_rdy(c_rdy), .c_addr(c_addr), .c_len(c_len),
    .c_busy(c_busy), .c_done(c_done), .m_rrdy(m_rrdy), .m_rval(m_rval), .m_rlen(m_rlen),
    .m_raddr(m_raddr), .m_rdata(m_rdata), .m_rdval(m_rdval), .o_val(o_val), .o_rdy(o_rdy),
    .o_data(o_data), .o_last(o_last));

  // Second instance with n-1 length encoding; always ready, never fed data.
  xlib_avalon_dma_r #(.BI(0)) u_dut0 (
    .clk(clk), .rst(rst), .c_val(c_val), .c_rdy(d0_c_rdy), .c_addr(c_addr), .c_len(c_len),
    .c_busy(d0_busy), .c_done(d0_done), .m_rrdy(1'b1), .m_rval(d0_rval), .m_rlen(d0_rlen),
    .m_raddr(d0_raddr), .m_rdata(32'h0), .m_rdval(1'b0), .o_val(d0_oval), .o_rdy(1'b1),
    .o_data(d0_odata), .o_last(d0_olast));

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0, cyc = 0;
  logic [31:0] eb_addr[$];
  int          eb_n[$];
  logic [31:0] ew[$];
  logic [31:0] bq_data[$];
  int          bq_due[$];
  int out_idx = 0, cur_tot = 0, outstanding = 0, bursts_seen = 0, words_acc = 0, last_n = 0;
  logic [31:0] last_addr = '0;
  bit done_expect = 0, cmd_done = 0, c_clr = 0;
  int done_cnt = 0;
  bit rrdy_rnd = 0, ordy_rnd = 0, bus_rnd = 0, rrdy_off = 0, ordy_off = 0;
  int bus_budget = -1;
  bit hold_v = 0;
  logic [31:0] hold_a = '0;
  logic [3:0]  hold_l = '0;
  bit d0_arm = 0;
  int d0_cnt = 0;
  logic [7:0] tag = 8'h00;

  typedef struct {
    logic [31:0] addr;
    int          len;
    bit          rnd;
    int          exp_nb;
    logic [31:0] exp_la;
    int          exp_ln;
  } vec_t;
  vec_t tbl[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] wdata(input logic [31:0] a);
    return {a[31:24] ^ tag ^ 8'h5A, a[23:0]};
  endfunction

  // Reference: split the command into bursts from the rules, list expected words.
  task automatic model_cmd(input logic [31:0] a, input int len);
    int rem, n, bw;
    logic [31:0] ad;
    rem = len;
    ad = a;
    eb_addr.delete(); eb_n.delete(); ew.delete();
    for (int i = 0; i < len; i++) ew.push_back(wdata(a + 32'(i * 4)));
    while (rem > 0) begin
      n = (rem < 8) ? rem : 8;
`ifdef XLIB_DMA_R_BOUNDARY_EN
      bw = (4096 - int'(ad[11:0])) / 4;
      if (bw < n) n = bw;
`else
      bw = 0;
`endif
      eb_addr.push_back(ad);
      eb_n.push_back(n);
      ad = ad + 32'(n * 4);
      rem = rem - n;
    end
    cur_tot = len;
    out_idx = 0;
  endtask

  // Everything that happens on the coming clock edge, judged from the settled outputs.
  task automatic observe();
    logic [31:0] a;
    int n;
    if (c_done || done_expect) begin
      chk("c_done", 32'(c_done), 32'(done_expect));
      if (c_done) begin done_cnt++; cmd_done = 1; end
    end
    done_expect = 0;
    if (hold_v) begin
      chk("hold_rval", 32'(m_rval), 32'd1);
      chk("hold_raddr", m_raddr, hold_a);
      chk("hold_rlen", 32'(m_rlen), 32'(hold_l));
    end
    if (d0_rval) begin
      d0_cnt++;
      if (d0_arm) begin chk("bi0_rlen", 32'(d0_rlen), 32'd2); d0_arm = 0; end
    end
    if (c_val && c_rdy) begin
      model_cmd(c_addr, int'(c_len));
      if (c_len == 16'd0) done_expect = 1;
      c_clr = 1;
    end
    if (m_rval && m_rrdy) begin
      if (eb_addr.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL extra_burst: got request at 0x%0h, expected none", m_raddr);
      end else begin
        a = eb_addr.pop_front();
        n = eb_n.pop_front();
        chk("raddr", m_raddr, a);
        chk("rlen", 32'(m_rlen), 32'(n));
      end
      outstanding += int'(m_rlen);
      chk("fifo_credit", 32'(outstanding <= DEPTH), 32'd1);
      bursts_seen++;
      words_acc += int'(m_rlen);
      last_addr = m_raddr;
      last_n = int'(m_rlen);
      for (int i = 0; i < int'(m_rlen); i++) begin
        bq_data.push_back(wdata(m_raddr + 32'(i * 4)));
        bq_due.push_back(cyc + 2);
      end
    end
    hold_v = m_rval && !m_rrdy;
    hold_a = m_raddr;
    hold_l = m_rlen;
    if (o_val && o_rdy) begin
      if (ew.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL extra_word: got 0x%0h, expected no word", o_data);
      end else begin
        chk("o_data", o_data, ew.pop_front());
        chk("o_last", 32'(o_last), 32'(out_idx == cur_tot - 1));
        out_idx++;
        outstanding--;
        if (out_idx == cur_tot) done_expect = 1;
      end
    end
  endtask

  task automatic cycle();
    if (c_clr) begin c_val = 1'b0; c_clr = 0; end
    m_rrdy = rrdy_off ? 1'b0 : (rrdy_rnd ? 1'($urandom_range(0, 1)) : 1'b1);
    o_rdy = ordy_off ? 1'b0 : (ordy_rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
    m_rdval = 1'b0;
    m_rdata = $urandom;
    if (bq_data.size() > 0 && bq_due[0] <= cyc && bus_budget != 0 &&
        !(bus_rnd && $urandom_range(0, 3) == 0)) begin
      m_rdval = 1'b1;
      m_rdata = bq_data.pop_front();
      void'(bq_due.pop_front());
      if (bus_budget > 0) bus_budget--;
    end
    @(negedge clk);
    observe();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic start_cmd(input logic [31:0] a, input int len);
    tag = tag + 8'd1;
    c_addr = a;
    c_len = 16'(len);
    c_val = 1'b1;
    c_clr = 0;
    cmd_done = 0;
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (!cmd_done && t < 3000) begin cycle(); t++; end
    chk("cmd_done", 32'(cmd_done), 32'd1);
    chk("bursts_left", 32'(eb_addr.size()), 32'd0);
    chk("words_left", 32'(ew.size()), 32'd0);
  endtask

  task automatic run_cmd(input logic [31:0] a, input int len);
    start_cmd(a, len);
    wait_done();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    c_val = 1'b0; c_clr = 0;
    m_rdval = 1'b0; m_rrdy = 1'b0; o_rdy = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    bq_data.delete(); bq_due.delete(); eb_addr.delete(); eb_n.delete(); ew.delete();
    outstanding = 0; done_expect = 0; hold_v = 0; bus_budget = -1; rrdy_off = 0;
    ordy_off = 0; cmd_done = 0; cur_tot = 0; out_idx = 0;
    chk("rst_c_rdy", 32'(c_rdy), 32'd1);
    chk("rst_c_busy", 32'(c_busy), 32'd0);
    chk("rst_c_done", 32'(c_done), 32'd0);
    chk("rst_m_rval", 32'(m_rval), 32'd0);
    chk("rst_m_rlen", 32'(m_rlen), 32'd0);
    chk("rst_m_raddr", m_raddr, 32'd0);
    chk("rst_o_val", 32'(o_val), 32'd0);
    chk("rst_o_data", o_data, 32'd0);
    chk("rst_o_last", 32'(o_last), 32'd0);
    rst = 1'b0;
  endtask

  initial begin
    int b, dc, t;
    logic [31:0] a;
    tbl[0] = '{32'h0000_0100, 20, 1'b0, 3, 32'h0000_0140, 4};
`ifdef XLIB_DMA_R_BOUNDARY_EN
    tbl[1] = '{32'h0000_0FF8, 8, 1'b0, 2, 32'h0000_1000, 6};
    tbl[3] = '{32'hFFFF_FFF0, 12, 1'b1, 2, 32'h0000_0000, 8};
`else
    tbl[1] = '{32'h0000_0FF8, 8, 1'b0, 1, 32'h0000_0FF8, 8};
    tbl[3] = '{32'hFFFF_FFF0, 12, 1'b1, 2, 32'h0000_0010, 4};
`endif
    tbl[2] = '{32'h0000_0000, 1, 1'b0, 1, 32'h0000_0000, 1};
    tbl[4] = '{32'h0000_1000, 33, 1'b1, 5, 32'h0000_1080, 1};
    tbl[5] = '{32'h0000_03F0, 64, 1'b1, 8, 32'h0000_04D0, 8};

    do_reset();
    @(posedge clk); #1;

    // Length encoding n-1 on the second instance, n on the main one.
    d0_arm = 1;
    d0_cnt = 0;
    run_cmd(32'h40, 3);
    chk("bi0_seen", 32'(d0_arm), 32'd0);
    chk("bi1_rlen", 32'(last_n), 32'd3);

    // Zero-length command completes without any request.
    dc = done_cnt; b = bursts_seen;
    run_cmd(32'h80, 0);
    chk("len0_done", 32'(done_cnt - dc), 32'd1);
    chk("len0_bursts", 32'(bursts_seen - b), 32'd0);

    foreach (tbl[i]) begin
      rrdy_rnd = tbl[i].rnd; ordy_rnd = tbl[i].rnd; bus_rnd = tbl[i].rnd;
      b = bursts_seen; dc = done_cnt;
      run_cmd(tbl[i].addr, tbl[i].len);
      chk($sformatf("tbl%0d_nbursts", i), 32'(bursts_seen - b), 32'(tbl[i].exp_nb));
      chk($sformatf("tbl%0d_last_addr", i), last_addr, tbl[i].exp_la);
      chk($sformatf("tbl%0d_last_n", i), 32'(last_n), 32'(tbl[i].exp_ln));
      chk($sformatf("tbl%0d_done", i), 32'(done_cnt - dc), 32'd1);
    end
    rrdy_rnd = 0; ordy_rnd = 0; bus_rnd = 0;

    // Stream stalled: requests stop once the FIFO space is fully committed.
    ordy_off = 1;
    words_acc = 0;
    start_cmd(32'h200, 40);
    repeat (60) cycle();
    chk("stall_words", 32'(words_acc), 32'd16);
    chk("stall_rval", 32'(m_rval), 32'd0);
    ordy_off = 0;
    wait_done();
    chk("stall_total", 32'(words_acc), 32'd40);

    // Bus not ready: request held stable, taken on the first ready cycle.
    rrdy_off = 1;
    start_cmd(32'h400, 8);
    repeat (12) cycle();
    chk("hold_rval_end", 32'(m_rval), 32'd1);
    chk("hold_raddr_end", m_raddr, 32'h400);
    b = bursts_seen;
    rrdy_off = 0;
    cycle();
    chk("hold_accept", 32'(bursts_seen - b), 32'd1);
    wait_done();

    // Random commands, many near a 4 KB boundary, random handshakes.
    rrdy_rnd = 1; ordy_rnd = 1; bus_rnd = 1;
    for (int i = 0; i < 8; i++) begin
      a = $urandom & 32'hFFFF_FFFC;
      if (i % 2 == 0) a = {a[31:12], 12'h000} + 32'(4096 - 4 * $urandom_range(1, 12));
      run_cmd(a, $urandom_range(1, 48));
    end
    rrdy_rnd = 0; ordy_rnd = 0; bus_rnd = 0;

    // Reset mid-command with 4 words outstanding, then a clean restart.
    chk("bi0_once", 32'(d0_cnt), 32'd1);
    bus_budget = 4;
    start_cmd(32'h800, 12);
    b = bursts_seen; t = 0;
    while (bursts_seen == b && t < 20) begin cycle(); t++; end
    chk("abort_first_burst", 32'(bursts_seen - b), 32'd1);
    rrdy_off = 1;
    repeat (12) cycle();
    chk("abort_busy", 32'(c_busy), 32'd1);
    chk("abort_rval", 32'(m_rval), 32'd1);
    chk("abort_popped", 32'(out_idx), 32'd4);
    dc = done_cnt;
    do_reset();
    bq_data.push_back(32'hDEAD_BEEF);
    bq_due.push_back(0);
    cycle();
    cycle();
    chk("idle_drop", 32'(o_val), 32'd0);
    run_cmd(32'h900, 2);
    chk("restart_done", 32'(done_cnt - dc), 32'd1);
    chk("restart_addr", last_addr, 32'h900);
    chk("restart_n", 32'(last_n), 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
